mac_stream_array: RTL
=====================

Name: mac_stream_array

Overview:
- Parametrised streaming dot-product engine; next generation of the fixed 8-lane, 4-bit, 3x3 MAC array.
- Each accepted beat supplies K activation/weight pairs. Products are reduced through a pipelined adder tree and accumulated across beats until in_last.
- Finished dot products are packed into LANES-wide output rows.
- New behaviour: signed/unsigned operand mode, multi-beat accumulation, partial-row flush, and a full valid/ready backpressure handshake.

Parameters:
- K, 9, operand pairs per beat.
- DW, 4, activation and weight width.
- LANES, 8, results per output row.
- ACC_W, 14, accumulator and result width; wraps modulo 2^ACC_W.
- IDX_W, 4, output row index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_signed  in  1  1 = operands are two's complement for this beat
- in_act  in  K*DW  activations, element 0 at MSB end
- in_wgt  in  K*DW  weights, same packing
- in_last  in  1  final beat of the current dot product
- in_eor  in  1  end of row; meaningful only with in_last
- out_valid  out  1  row valid
- out_ready  in  1  row consumed when out_valid && out_ready
- out_data  out  LANES*ACC_W  row results, lane 0 at MSB end
- out_cnt  out  clog2(LANES+1)  number of populated lanes
- out_idx  out  IDX_W  row sequence number

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_cnt=0, out_idx=0. All pipeline valids, the accumulator, the partial row and the lane counter are cleared.
- Reset asserted mid-row or mid-accumulation discards everything in flight; no partial row is emitted.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall, combinational, so it is 1 after reset. Every pipeline register holds while stall=1.
- Multiply stage (registered): K products of width 2*DW.
  - Unsigned: both operands zero-extended.
  - Signed (in_signed=1): both operands two's complement.
  - The in_signed, in_last and in_eor flags travel with the beat.
- Adder tree: clog2(K) registered levels; each level pairs neighbours and passes an odd leftover through.
  - Sum is sign-extended (signed) or zero-extended (unsigned) to ACC_W.
- Accumulate stage:
  - acc_next = (first beat of a product ? 0 : acc) + dot, truncated to ACC_W.
  - A beat following a beat with in_last is a first beat.
- Row assembly: on a last-beat result, the result is written to lane lane_cnt and lane_cnt increments.
  - Row completes when lane_cnt reaches LANES, or when the result carries in_eor.
  - On completion: out_data loads the row with unpopulated lanes zeroed, out_cnt = lanes populated, out_valid=1, lane_cnt=0.
- Output hold: out_data, out_cnt and out_idx stay stable while out_valid && !out_ready.
- Row handshake: out_idx increments and wraps at 2^IDX_W. out_valid drops unless a new row completes in the same cycle; a back-to-back row is allowed.
- Latency: LAT = 2 + clog2(K) + 1 non-stalled cycles from the accepting edge of the final beat to out_valid (LAT=7 for K=9).
- Simultaneous in_eor with the LANES-th result: a single row with out_cnt=LANES; no empty row follows.
- in_eor on a non-last beat is ignored.
- in_signed is required constant within a dot product. Each beat's product uses its own flag; no check is made.

Decomposition:
- Package mac_pkg holds:
  - localparam functions for tree depth, LAT and out_cnt width.
  - typedef beat_flags_t {signed, last, eor}.
- Sub-module mac_dot_tree: K multipliers plus the registered adder tree, with an enable input driven by !stall and a valid/flags sideband.
- Accumulator, row assembly and handshake stay in mac_stream_array.

Test Plan:
- Unsigned, 8 single-beat products, all act=15 and wgt=15, out_ready=1 -> one row, every lane 2025, out_cnt=8, out_idx=0, out_valid exactly 7 cycles after the 8th beat.
- Signed, one beat, act=4'h8 (-8), wgt=7 ×9, in_last=1, in_eor=1 -> lane0=14'h3E08 (-504), out_cnt=1, lanes 1..7 = 0.
- Three beats, act=1 and wgt=2, in_last on the third, then five more single-beat products -> lane0=54, following lanes correct, no cross-product leakage.
- in_eor on the third result -> row with out_cnt=3, lanes 3..7 zero; next row starts at lane 0 with out_idx=1.
- Output stall: hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 throughout, out_data unchanged, no beats lost; after release the results match a stall-free reference.
- Assert rst_n low with 5 lanes filled and 2 beats in the pipeline -> all outputs 0 immediately; the next product lands in lane 0 with out_idx=0.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_stream_array shared package
// beat flag bundle and elaboration-time sizing helpers
package mac_pkg;

   typedef struct packed {
      logic sgn;
      logic last;
      logic eor;
   } beat_flags_t;

   function automatic int tree_depth(input int k);
      return $clog2(k);
   endfunction

   function automatic int lat_cycles(input int k);
      return 3 + $clog2(k);
   endfunction

   function automatic int cnt_w(input int lanes);
      return $clog2(lanes + 1);
   endfunction

   function automatic int tree_nodes(input int k, input int lvl);
      return (k + (1 << lvl) - 1) >> lvl;
   endfunction

endpackage

// File: rtl/mac_stream_array_if.sv
// mac_stream_array stream interface
// beat input and row output handshakes
interface mac_stream_array_if import mac_pkg::*; #(
   parameter int K     = 9,
   parameter int DW    = 4,
   parameter int LANES = 8,
   parameter int ACC_W = 14,
   parameter int IDX_W = 4
) ();
   localparam int CW = cnt_w(LANES);

   logic                   in_valid;
   logic                   in_ready;
   logic                   in_signed;
   logic [K*DW-1:0]        in_act;
   logic [K*DW-1:0]        in_wgt;
   logic                   in_last;
   logic                   in_eor;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*ACC_W-1:0] out_data;
   logic [CW-1:0]          out_cnt;
   logic [IDX_W-1:0]       out_idx;

   modport master (
      output in_valid, in_signed, in_act, in_wgt,
      output in_last, in_eor, out_ready,
      input  in_ready, out_valid, out_data,
      input  out_cnt, out_idx
   );

   modport slave (
      input  in_valid, in_signed, in_act, in_wgt,
      input  in_last, in_eor, out_ready,
      output in_ready, out_valid, out_data,
      output out_cnt, out_idx
   );
endinterface

// File: rtl/mac_dot_tree.sv
// mac_dot_tree: K multipliers and registered adder tree
// operand register, product register, clog2(K) sum levels
module mac_dot_tree import mac_pkg::*; #(
   parameter int K     = 9,
   parameter int DW    = 4,
   parameter int ACC_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_vld,
   input  beat_flags_t       i_flags,
   input  logic [K*DW-1:0]   i_act,
   input  logic [K*DW-1:0]   i_wgt,
   output logic              o_vld,
   output beat_flags_t       o_flags,
   output logic [ACC_W-1:0]  o_sum
);
   localparam int TD = tree_depth(K);
   localparam int PW = 2 * DW;

   logic             r_vld0;
   beat_flags_t      r_fl0;
   logic [K*DW-1:0]  r_act;
   logic [K*DW-1:0]  r_wgt;
   logic             r_vld1;
   beat_flags_t      r_fl1;
   logic [PW-1:0]    r_prod [K];
   logic [PW-1:0]    w_prod [K];
   logic [ACC_W-1:0] w_node [TD+1][K];
   logic [ACC_W-1:0] w_next [TD][K];
   logic [ACC_W-1:0] r_lvl  [TD][K];
   logic [TD-1:0]    r_tv;
   beat_flags_t      r_tf   [TD];

   for (genvar i = 0; i < K; i++) begin : g_mul
      logic signed [DW:0] w_a;
      logic signed [DW:0] w_b;
      assign w_a = {r_fl0.sgn & r_act[(K-i)*DW-1],
                    r_act[(K-1-i)*DW +: DW]};
      assign w_b = {r_fl0.sgn & r_wgt[(K-i)*DW-1],
                    r_wgt[(K-1-i)*DW +: DW]};
      assign w_prod[i] = PW'(w_a) * PW'(w_b);
      assign w_node[0][i] = r_fl1.sgn
                          ? ACC_W'($signed(r_prod[i]))
                          : ACC_W'(r_prod[i]);
   end

   for (genvar l = 0; l < TD; l++) begin : g_lvl
      localparam int N = tree_nodes(K, l);
      for (genvar j = 0; j < K; j++) begin : g_node
         if (2*j+1 < N) begin : g_add
            assign w_next[l][j] = w_node[l][2*j]
                                + w_node[l][2*j+1];
         end else if (2*j < N) begin : g_pass
            assign w_next[l][j] = w_node[l][2*j];
         end else begin : g_zero
            assign w_next[l][j] = '0;
         end
         assign w_node[l+1][j] = r_lvl[l][j];
      end
   end

   // advance operands, products and sum levels when not stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld0 <= 1'b0;
         r_fl0  <= '0;
         r_act  <= '0;
         r_wgt  <= '0;
         r_vld1 <= 1'b0;
         r_fl1  <= '0;
         r_tv   <= '0;
         for (int i = 0; i < K; i++) r_prod[i] <= '0;
         for (int l = 0; l < TD; l++) begin
            r_tf[l] <= '0;
            for (int j = 0; j < K; j++) r_lvl[l][j] <= '0;
         end
      end else if (i_en) begin
         r_vld0 <= i_vld;
         r_fl0  <= i_flags;
         r_act  <= i_act;
         r_wgt  <= i_wgt;
         r_vld1 <= r_vld0;
         r_fl1  <= r_fl0;
         for (int i = 0; i < K; i++) r_prod[i] <= w_prod[i];
         r_tv[0] <= r_vld1;
         r_tf[0] <= r_fl1;
         for (int l = 1; l < TD; l++) begin
            r_tv[l] <= r_tv[l-1];
            r_tf[l] <= r_tf[l-1];
         end
         for (int l = 0; l < TD; l++)
            for (int j = 0; j < K; j++) r_lvl[l][j] <= w_next[l][j];
      end
   end

   assign o_vld   = r_tv[TD-1];
   assign o_flags = r_tf[TD-1];
   assign o_sum   = r_lvl[TD-1][0];
endmodule

// File: rtl/mac_stream_array.sv
// mac_stream_array: streaming dot products packed into rows
// accumulates beats, assembles LANES-wide rows, valid/ready out
module mac_stream_array import mac_pkg::*; #(
   parameter int K     = 9,
   parameter int DW    = 4,
   parameter int LANES = 8,
   parameter int ACC_W = 14,
   parameter int IDX_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   mac_stream_array_if.slave bus
);
   localparam int CW = cnt_w(LANES);

   logic                   w_en;
   beat_flags_t            w_in_fl;
   logic                   w_t_vld;
   beat_flags_t            w_t_fl;
   logic [ACC_W-1:0]       w_t_sum;
   logic                   r_first;
   logic                   r_a_vld;
   beat_flags_t            r_a_fl;
   logic [ACC_W-1:0]       r_acc;
   logic [ACC_W-1:0]       r_row [LANES];
   logic [ACC_W-1:0]       w_row [LANES];
   logic [CW-1:0]          r_lane;
   logic [CW-1:0]          w_cnt_nx;
   logic                   w_wr;
   logic                   w_done;
   logic [LANES*ACC_W-1:0] w_pack;
   logic                   r_out_vld;
   logic [LANES*ACC_W-1:0] r_out_data;
   logic [CW-1:0]          r_out_cnt;
   logic [IDX_W-1:0]       r_out_idx;

   assign w_en = !(r_out_vld && !bus.out_ready);
   assign bus.in_ready = w_en;
   assign w_in_fl = '{sgn:  bus.in_signed,
                      last: bus.in_last,
                      eor:  bus.in_eor};

   mac_dot_tree #(.K(K), .DW(DW), .ACC_W(ACC_W)) u_tree (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en),
      .i_vld   (bus.in_valid),
      .i_flags (w_in_fl),
      .i_act   (bus.in_act),
      .i_wgt   (bus.in_wgt),
      .o_vld   (w_t_vld),
      .o_flags (w_t_fl),
      .o_sum   (w_t_sum)
   );

   // accumulate beat sums, restarting after a last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_first <= 1'b1;
         r_a_vld <= 1'b0;
         r_a_fl  <= '0;
         r_acc   <= '0;
      end else if (w_en) begin
         r_a_vld <= w_t_vld;
         if (w_t_vld) begin
            r_acc   <= (r_first ? '0 : r_acc) + w_t_sum;
            r_first <= w_t_fl.last;
            r_a_fl  <= w_t_fl;
         end
      end
   end

   assign w_wr     = w_en && r_a_vld && r_a_fl.last;
   assign w_cnt_nx = r_lane + 1'b1;
   assign w_done   = w_wr && (w_cnt_nx == CW'(LANES) || r_a_fl.eor);

   // partial row with the finished product dropped into its lane
   always_comb begin
      w_pack = '0;
      for (int i = 0; i < LANES; i++) begin
         w_row[i] = (w_wr && r_lane == CW'(i)) ? r_acc : r_row[i];
         w_pack[(LANES-1-i)*ACC_W +: ACC_W] = w_row[i];
      end
   end

   // hold the partial row; clear it once it is emitted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane <= '0;
         for (int i = 0; i < LANES; i++) r_row[i] <= '0;
      end else if (w_wr) begin
         r_lane <= w_done ? '0 : w_cnt_nx;
         for (int i = 0; i < LANES; i++)
            r_row[i] <= w_done ? '0 : w_row[i];
      end
   end

   // output row register and sequence number
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_cnt  <= '0;
         r_out_idx  <= '0;
      end else if (w_en) begin
         if (r_out_vld) r_out_idx <= r_out_idx + 1'b1;
         r_out_vld <= w_done;
         if (w_done) begin
            r_out_data <= w_pack;
            r_out_cnt  <= w_cnt_nx;
         end
      end
   end

   assign bus.out_valid = r_out_vld;
   assign bus.out_data  = r_out_data;
   assign bus.out_cnt   = r_out_cnt;
   assign bus.out_idx   = r_out_idx;
endmodule
